// File: rtl/supv_pkg.sv
// Shared types and defaults for the balance supervisor: state encoding,
// settle/overspeed sample counts and shutdown timer widths.
package supv_pkg;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        SETTLE = 3'd1,
        RUN    = 3'd2,
        WARN   = 3'd3,
        SHUTDN = 3'd4
    } supv_state_t;

    localparam int SETTLE_SMPLS_DEF = 64;
    localparam int FAST_SMPLS_DEF   = 8;
    localparam int TMR_W_SIM        = 10;
    localparam int TMR_W_FULL       = 20;

endpackage

// File: rtl/sup_tmr.sv
// Saturating up-counter with synchronous clear (dominant over enable) and a
// flag that is high while the count equals LIMIT.
module sup_tmr #(
    parameter int             W     = 8,
    parameter logic [W-1:0]   LIMIT = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic full
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !(&cnt)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign full = (cnt == LIMIT);

endmodule

// File: rtl/balance_supervisor.sv
// Supervisory FSM sequencing balance_cntrl: power-on settle, overspeed warning,
// deferred power-down until the rider has stepped off, and battery warning.
module balance_supervisor
    import supv_pkg::*;
#(
    parameter int SETTLE_SMPLS = SETTLE_SMPLS_DEF,
    parameter int FAST_SMPLS   = FAST_SMPLS_DEF,
    parameter bit fast_sim     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwr_req,
    input  logic       vld,
    input  logic       rider_off,
    input  logic       too_fast,
    input  logic       batt_low,
    output logic       pwr_up,
    output logic       steer_allow,
    output logic       ovr_spd,
    output logic       batt_warn,
    output logic [2:0] state
);

    localparam int TMR_W = fast_sim ? TMR_W_SIM : TMR_W_FULL;

    supv_state_t state_q, state_d;
    logic scnt_last, fcnt_last, tmr_full;
    logic to_off, scnt_clr, fcnt_clr, tmr_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= OFF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF: begin
                if (pwr_req && !batt_low) state_d = SETTLE;
            end
            SETTLE: begin
                if (pwr_req || tmr_full)                    state_d = OFF;
                else if (vld && !rider_off && scnt_last)    state_d = RUN;
            end
            RUN: begin
                if (pwr_req)                                state_d = rider_off ? OFF : SHUTDN;
                else if (tmr_full)                          state_d = OFF;
                else if (vld && too_fast && fcnt_last)      state_d = WARN;
            end
            WARN: begin
                if (pwr_req)                                state_d = rider_off ? OFF : SHUTDN;
                else if (tmr_full)                          state_d = OFF;
                else if (vld && !too_fast)                  state_d = RUN;
            end
            SHUTDN: begin
                if (pwr_req)                                state_d = RUN;
                else if (tmr_full)                          state_d = OFF;
            end
            default: state_d = OFF;
        endcase
    end

    // Counters only run in the states that use them; landing in OFF wipes all three.
    assign to_off   = (state_d == OFF);
    assign scnt_clr = to_off || (state_q != SETTLE) || rider_off;
    assign fcnt_clr = to_off || !((state_q == RUN) || (state_q == WARN)) || (vld && !too_fast);
    assign tmr_clr  = to_off || (state_q == OFF) || !rider_off || ((state_q == SHUTDN) && pwr_req);

    sup_tmr #(.W(7), .LIMIT(7'(SETTLE_SMPLS - 1))) u_scnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (scnt_clr),
        .en   (vld),
        .full (scnt_last)
    );

    sup_tmr #(.W(4), .LIMIT(4'(FAST_SMPLS - 1))) u_fcnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (fcnt_clr),
        .en   (vld && too_fast),
        .full (fcnt_last)
    );

    sup_tmr #(.W(TMR_W)) u_tmr (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (1'b1),
        .full (tmr_full)
    );

    // Outputs are decoded from the registered state, so they trail it by one clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwr_up      <= 1'b0;
            steer_allow <= 1'b0;
            ovr_spd     <= 1'b0;
            batt_warn   <= 1'b0;
        end else begin
            pwr_up      <= (state_q != OFF);
            steer_allow <= (state_q == RUN);
            ovr_spd     <= (state_q == WARN);
            batt_warn   <= batt_low && pwr_up;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_balance_supervisor.sv
// Self-checking bench for balance_supervisor (fast_sim timer); observed vector is
// {state, pwr_up, steer_allow, ovr_spd, batt_warn}.
module tb_balance_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwr_req, vld, rider_off, too_fast, batt_low;
    logic       pwr_up, steer_allow, ovr_spd, batt_warn;
    logic [2:0] state;

    logic [6:0] exp_q[$];
    logic [6:0] got, exp_v;
    int         checks = 0;
    int         errors = 0;

    balance_supervisor #(.fast_sim(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .pwr_req     (pwr_req),
        .vld         (vld),
        .rider_off   (rider_off),
        .too_fast    (too_fast),
        .batt_low    (batt_low),
        .pwr_up      (pwr_up),
        .steer_allow (steer_allow),
        .ovr_spd     (ovr_spd),
        .batt_warn   (batt_warn),
        .state       (state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_pwr();
        pwr_req = 1'b1;
        tick();
        pwr_req = 1'b0;
    endtask

    task automatic send_vld(input int n);
        for (int i = 0; i < n; i++) begin
            vld = 1'b1;
            tick();
        end
        vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pwr_req = 0; vld = 0; rider_off = 0; too_fast = 0; batt_low = 0;
        #2;
        exp_q.push_back(7'b000_0000);
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reset_hold: got %b exp %b", got, exp_v); end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        exp_q.push_back(7'b000_0000);
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reset_release: got %b exp %b", got, exp_v); end
    endtask

    task automatic test_power_on();
        exp_q.push_back({3'd1, 4'b0000});
        pulse_pwr();
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL pwr_on_state: got %b exp %b", got, exp_v); end
        exp_q.push_back({3'd1, 4'b1000});
        tick();
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL pwr_on_pwr_up: got %b exp %b", got, exp_v); end
        exp_q.push_back({3'd1, 4'b1000});
        send_vld(63);
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL settle_63: got %b exp %b", got, exp_v); end
        exp_q.push_back({3'd2, 4'b1000});
        send_vld(1);
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL settle_64: got %b exp %b", got, exp_v); end
        exp_q.push_back({3'd2, 4'b1100});
        tick();
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL run_steer: got %b exp %b", got, exp_v); end
    endtask

    task automatic test_overspeed();
        too_fast = 1'b1; send_vld(7);
        too_fast = 1'b0;
        exp_q.push_back({3'd2, 4'b1100});
        send_vld(1); tick();
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL fast7_clean: got %b exp %b", got, exp_v); end
        too_fast = 1'b1;
        exp_q.push_back({3'd2, 4'b1100});
        send_vld(7);
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL fcnt_cleared: got %b exp %b", got, exp_v); end
        exp_q.push_back({3'd3, 4'b1100});
        send_vld(1);
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL fast8_warn: got %b exp %b", got, exp_v); end
        too_fast = 1'b0;
        exp_q.push_back({3'd3, 4'b1010});
        tick();
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL warn_outputs: got %b exp %b", got, exp_v); end
        exp_q.push_back({3'd2, 4'b1100});
        send_vld(1); tick();
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL warn_recover: got %b exp %b", got, exp_v); end
    endtask

    task automatic test_settle_restart();
        rider_off = 1'b1;
        exp_q.push_back({3'd0, 4'b1100});
        pulse_pwr();
        rider_off = 1'b0;
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL run_off_rider_off: got %b exp %b", got, exp_v); end
        exp_q.push_back(7'b000_0000);
        tick();
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL off_outputs: got %b exp %b", got, exp_v); end
        pulse_pwr();
        send_vld(40);
        rider_off = 1'b1; tick(); rider_off = 1'b0;
        exp_q.push_back({3'd1, 4'b1000});
        send_vld(63);
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL settle_restart_63: got %b exp %b", got, exp_v); end
        exp_q.push_back({3'd2, 4'b1000});
        send_vld(1);
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL settle_restart_64: got %b exp %b", got, exp_v); end
        tick();
    endtask

    task automatic test_shutdown();
        int n;
        exp_q.push_back({3'd4, 4'b1100});
        pulse_pwr();
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL shutdn_enter: got %b exp %b", got, exp_v); end
        exp_q.push_back({3'd4, 4'b1000});
        tick();
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL shutdn_outputs: got %b exp %b", got, exp_v); end
        rider_off = 1'b1; repeat (500) tick();
        rider_off = 1'b0; tick();
        rider_off = 1'b1;
        exp_q.push_back({3'd4, 4'b1000});
        repeat (1022) tick();
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL tmr_blip_restart: got %b exp %b", got, exp_v); end
        n = 0;
        while (state !== 3'd0 && n < 4) begin tick(); n++; end
        if (state !== 3'd0) $display("Timeout waiting for auto power-down after %0d clks", n);
        exp_q.push_back({3'd0, 4'b1000});
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL tmr_expire_off: got %b exp %b", got, exp_v); end
        exp_q.push_back(7'b000_0000);
        tick();
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL tmr_expire_pwr_dn: got %b exp %b", got, exp_v); end
        rider_off = 1'b0;
    endtask

    task automatic test_batt();
        batt_low = 1'b1;
        exp_q.push_back(7'b000_0000);
        pulse_pwr(); tick();
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL batt_low_ignore: got %b exp %b", got, exp_v); end
        batt_low = 1'b0;
        pulse_pwr();
        send_vld(64);
        batt_low = 1'b1;
        exp_q.push_back({3'd2, 4'b1101});
        tick();
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL batt_warn_run: got %b exp %b", got, exp_v); end
        batt_low = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        vld = 1'b1;
        #3 rst = 1'b1;
        #1;
        exp_q.push_back(7'b000_0000);
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL async_reset: got %b exp %b", got, exp_v); end
        #2 rst = 1'b0;
        vld = 1'b0;
        exp_q.push_back(7'b000_0000);
        tick();
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL after_reset: got %b exp %b", got, exp_v); end
        pulse_pwr();
        send_vld(64);
        tick();
        too_fast = 1'b1;
        send_vld(7);
        vld = 1'b1; pwr_req = 1'b1;
        exp_q.push_back({3'd4, 4'b1100});
        tick();
        vld = 1'b0; pwr_req = 1'b0; too_fast = 1'b0;
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL pwr_req_beats_fast: got %b exp %b", got, exp_v); end
        exp_q.push_back({3'd4, 4'b1000});
        tick();
        got = {state, pwr_up, steer_allow, ovr_spd, batt_warn}; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL shutdn_no_ovr: got %b exp %b", got, exp_v); end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_overspeed();
        test_settle_restart();
        test_shutdown();
        test_batt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
